pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Pipeline sequencing block for the five-stage MIPS core. Owns the PC and the instruction/PC register chain F→D→E→M→W, and consumes the hazard detector's `stall` output: freezes F and D, injects a bubble into E, and steers the PC on D-stage branch/jump decisions with one delay slot. Also keeps free-running stall and retirement counters for debug.

## Interface
Parameters:
- RESET_PC, 32'h0000_3000, value loaded into pc_f on reset
- CNT_W, 32, width of both performance counters

Ports:
- clk  in  1  the core clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately while low
- stall  in  1  hazard request from the stall detector, evaluated against ir_d/ir_e/ir_m
- instr_f  in  32  instruction-memory read data for address pc_f (combinational from IM)
- br_taken  in  1  D-stage beq compare result (valid only when stall=0)
- br_target  in  32  branch target for the D instruction
- jump  in  1  D instruction is j/jal/jr
- jump_target  in  32  jump target (index concat or rs value)
- pc_f  out  32  fetch address
- ir_d, pc_d  out  32 each  D-stage instruction and PC
- ir_e, pc_e  out  32 each  E-stage instruction and PC
- ir_m, pc_m  out  32 each  M-stage instruction and PC
- ir_w, pc_w  out  32 each  W-stage instruction and PC
- stall_cnt  out  CNT_W  cycles with stall=1 since reset
- retired_cnt  out  CNT_W  non-nop instructions that left W since reset

## Operation
- Reset (reset=0): pc_f=RESET_PC; every ir_*/pc_* = 0 (nop); both counters = 0. Applies asynchronously, including mid-stall or mid-redirect; no pending redirect survives.
- Normal edge (stall=0): pc_f←npc; ir_d←instr_f, pc_d←pc_f; E←D; M←E; W←M.
- Stall edge (stall=1): pc_f, ir_d, pc_d hold; ir_e←0, pc_e←0 (bubble); M←E, W←M advance normally. Multi-cycle stalls repeat this every cycle.
- npc selection (stall=0 only): jump=1 → jump_target; else br_taken=1 → br_target; else pc_f+4. jump has priority if both are asserted.
- When stall=1, br_taken/jump are ignored, because D operands may be stale. The D instruction re-evaluates on the first non-stall cycle.
- Delay slot: the instruction already fetched at pc_f when D redirects always enters D; there is no flush path.
- pc_f+4 is modulo 2^32 (0xFFFF_FFFC→0x0000_0000). Targets are used unmodified; no alignment check.
- stall_cnt += 1 on every edge with stall=1.
- retired_cnt += 1 on every edge where the current ir_w ≠ 0.
- Both counters wrap modulo 2^CNT_W.

## Timing
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Fetch-to-W latency: 4 edges from instr_f sampled into ir_d until it is in ir_w, absent stalls; each stall cycle adds 1.
- Stall response: takes effect on the same edge at which stall=1 is sampled.
- Bubble timing: the bubble appears in ir_e after that edge, in ir_m one edge later, and in ir_w two edges later.
- Redirect: a branch in D with stall=0 at edge k gives pc_f=target after edge k. The delay-slot instruction is in ir_d after edge k, and the target instruction is in ir_d after edge k+1.
- stall_cnt updates on the same edge as the stall action.
- retired_cnt counts the W instruction as it leaves.

## Test plan
- Reset mid-run: pull reset low between edges while ir_e≠0 → pc_f=0x3000, all ir/pc=0, counters=0 immediately. Outputs stay so while reset=0, and the first edge after release fetches 0x3000.
- Straight line: IM holds addu/ori/lw/sw at 0x3000–0x300C, stall=0 → pc_f steps by 4. ir_d=instr@0x3000 after edge 1, and ir_w=instr@0x3000 after edge 4. retired_cnt=1 after edge 5.
- Load-use stall: stall=1 for 2 cycles with pc_f=0x3010 → pc_f and ir_d held, ir_e=0 for two edges, stall_cnt=2. M/W keep advancing, and ir_m=0 one edge after the first bubble.
- Taken beq: beq at 0x3008 in D, br_taken=1, br_target=0x3020 → ir_d=instr@0x300C (delay slot), then pc_f=0x3020. The next ir_d is instr@0x3020.
- Branch under stall: br_taken=1 with stall=1 → pc_f holds at 0x300C. Next cycle stall=0, br_taken=1 → pc_f=0x3020. Also drive jump=1 and br_taken=1 together with jump_target=0x3040 → pc_f=0x3040.
- Wrap: jump_target=0xFFFF_FFFC → pc_f=0xFFFF_FFFC, then 0x0000_0000 on the next non-stall edge.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline sequencer: owns the PC and the F->D->E->M->W instruction/PC chain,
// applies hazard stalls as an E-stage bubble, and redirects fetch with one delay slot.
module pipe_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic [31:0]      instr_f,
  input  logic             br_taken,
  input  logic [31:0]      br_target,
  input  logic             jump,
  input  logic [31:0]      jump_target,
  output logic [31:0]      pc_f,
  output logic [31:0]      ir_d,
  output logic [31:0]      pc_d,
  output logic [31:0]      ir_e,
  output logic [31:0]      pc_e,
  output logic [31:0]      ir_m,
  output logic [31:0]      pc_m,
  output logic [31:0]      ir_w,
  output logic [31:0]      pc_w,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] retired_cnt
);

  localparam int unsigned XLEN = 32;

  logic [XLEN-1:0] npc;

  // Next fetch address; only consumed on non-stall edges, so stale D decisions are ignored.
  always_comb begin
    npc = XLEN'(pc_f + XLEN'(4));
    if (jump) begin
      npc = jump_target;
    end else if (br_taken) begin
      npc = br_target;
    end
  end

  // F and D freeze under stall while E takes a bubble; M and W always advance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_f <= RESET_PC;
      ir_d <= '0;
      pc_d <= '0;
      ir_e <= '0;
      pc_e <= '0;
      ir_m <= '0;
      pc_m <= '0;
      ir_w <= '0;
      pc_w <= '0;
    end else begin
      if (stall) begin
        ir_e <= '0;
        pc_e <= '0;
      end else begin
        pc_f <= npc;
        ir_d <= instr_f;
        pc_d <= pc_f;
        ir_e <= ir_d;
        pc_e <= pc_d;
      end
      ir_m <= ir_e;
      pc_m <= pc_e;
      ir_w <= ir_m;
      pc_w <= pc_m;
    end
  end

  // Debug counters: stall cycles, and non-nop instructions leaving W.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt   <= '0;
      retired_cnt <= '0;
    end else begin
      if (stall) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (ir_w != '0) begin
        retired_cnt <= retired_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios plus random stalls/redirects against a stage-array model.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, br_taken, jump;
  logic [31:0] instr_f, br_target, jump_target;
  logic [31:0] pc_f, ir_d, pc_d, ir_e, pc_e, ir_m, pc_m, ir_w, pc_w;
  logic [31:0] stall_cnt, retired_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: a fetch PC, four stage slots (0=D .. 3=W) and two counters.
  logic [31:0] m_pc;
  logic [31:0] m_ir [4];
  logic [31:0] m_pcs[4];
  logic [31:0] m_sc, m_rc;

  pipe_ctrl #(.RESET_PC(32'h0000_3000), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .stall(stall), .instr_f(instr_f),
    .br_taken(br_taken), .br_target(br_target), .jump(jump), .jump_target(jump_target),
    .pc_f(pc_f), .ir_d(ir_d), .pc_d(pc_d), .ir_e(ir_e), .pc_e(pc_e),
    .ir_m(ir_m), .pc_m(pc_m), .ir_w(ir_w), .pc_w(pc_w),
    .stall_cnt(stall_cnt), .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  // Instruction memory: a short program at 0x3000, a nop every 32 words, otherwise a hash.
  function automatic logic [31:0] im(input logic [31:0] a);
    case (a)
      32'h0000_3000: return 32'h0085_1021;
      32'h0000_3004: return 32'h34a5_0001;
      32'h0000_3008: return 32'h8c86_0000;
      32'h0000_300C: return 32'hac86_0004;
      default:       return (a[6:2] == 5'h1F) ? 32'h0 : {a[31:2] ^ 30'h2aa5_5a5a, 2'b11};
    endcase
  endfunction

  assign instr_f = im(pc_f);

  task automatic model_reset();
    m_pc = 32'h0000_3000;
    for (int i = 0; i < 4; i++) begin
      m_ir[i]  = '0;
      m_pcs[i] = '0;
    end
    m_sc = '0;
    m_rc = '0;
  endtask

  task automatic model_edge(input logic s, input logic b, input logic j,
                            input logic [31:0] bt, input logic [31:0] jt);
    if (m_ir[3] != 0) m_rc = m_rc + 32'd1;
    for (int i = 3; i >= 2; i--) begin
      m_ir[i]  = m_ir[i-1];
      m_pcs[i] = m_pcs[i-1];
    end
    if (s) begin
      m_ir[1]  = '0;
      m_pcs[1] = '0;
      m_sc     = m_sc + 32'd1;
    end else begin
      m_ir[1]  = m_ir[0];
      m_pcs[1] = m_pcs[0];
      m_ir[0]  = im(m_pc);
      m_pcs[0] = m_pc;
      m_pc     = j ? jt : (b ? bt : m_pc + 32'd4);
    end
  endtask

  // One clock edge with the given inputs; returns 1 time unit after the edge.
  task automatic step(input logic s, input logic b, input logic [31:0] bt,
                      input logic j, input logic [31:0] jt);
    stall = s; br_taken = b; br_target = bt; jump = j; jump_target = jt;
    @(posedge clk);
    model_edge(s, b, j, bt, jt);
    #1;
  endtask

  task automatic do_reset();
    stall = 0; br_taken = 0; jump = 0; br_target = '0; jump_target = '0;
    reset = 1'b0;
    #2;
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 0; br_taken = 0; jump = 0; br_target = '0; jump_target = '0;
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (pc_f !== 32'h0000_3000) begin
      n_fail++; $display("FAIL reset_pc_f: got %h expected %h", pc_f, 32'h0000_3000);
    end
    n_checks++;
    if ({ir_d, pc_d, ir_e, pc_e, ir_m, pc_m, ir_w, pc_w} !== 256'h0) begin
      n_fail++; $display("FAIL reset_chain: got %h expected 0", {ir_d, pc_d, ir_e, pc_e, ir_m, pc_m, ir_w, pc_w});
    end
    n_checks++;
    if ({stall_cnt, retired_cnt} !== 64'h0) begin
      n_fail++; $display("FAIL reset_counters: got %h expected 0", {stall_cnt, retired_cnt});
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_straight_line();
    do_reset();
    step(0, 0, '0, 0, '0);
    n_checks++;
    if (ir_d !== 32'h0085_1021 || pc_d !== 32'h0000_3000 || pc_f !== 32'h0000_3004) begin
      n_fail++; $display("FAIL straight_edge1: got ir_d=%h pc_d=%h pc_f=%h expected 00851021 00003000 00003004", ir_d, pc_d, pc_f);
    end
    for (int i = 0; i < 3; i++) step(0, 0, '0, 0, '0);
    n_checks++;
    if (ir_w !== 32'h0085_1021 || pc_w !== 32'h0000_3000 || pc_f !== 32'h0000_3010) begin
      n_fail++; $display("FAIL straight_edge4: got ir_w=%h pc_w=%h pc_f=%h expected 00851021 00003000 00003010", ir_w, pc_w, pc_f);
    end
    n_checks++;
    if (ir_m !== 32'h34a5_0001 || ir_e !== 32'h8c86_0000 || ir_d !== 32'hac86_0004) begin
      n_fail++; $display("FAIL straight_chain: got m=%h e=%h d=%h expected 34a50001 8c860000 ac860004", ir_m, ir_e, ir_d);
    end
  endtask

  // Runs on from straight_line with pc_f=0x3010.
  task automatic test_load_use_stall();
    step(1, 0, '0, 0, '0);
    n_checks++;
    if (pc_f !== 32'h0000_3010 || ir_d !== 32'hac86_0004 || ir_e !== 32'h0 || pc_e !== 32'h0) begin
      n_fail++; $display("FAIL stall1: got pc_f=%h ir_d=%h ir_e=%h pc_e=%h expected 00003010 ac860004 0 0", pc_f, ir_d, ir_e, pc_e);
    end
    n_checks++;
    if (ir_m !== 32'h8c86_0000 || ir_w !== 32'h34a5_0001 || stall_cnt !== 32'd1 || retired_cnt !== 32'd1) begin
      n_fail++; $display("FAIL stall1_mw: got m=%h w=%h sc=%0d rc=%0d expected 8c860000 34a50001 1 1", ir_m, ir_w, stall_cnt, retired_cnt);
    end
    step(1, 1, 32'h0000_5000, 1, 32'h0000_6000);
    n_checks++;
    if (pc_f !== 32'h0000_3010 || ir_e !== 32'h0 || ir_m !== 32'h0 || stall_cnt !== 32'd2) begin
      n_fail++; $display("FAIL stall2: got pc_f=%h ir_e=%h ir_m=%h sc=%0d expected 00003010 0 0 2", pc_f, ir_e, ir_m, stall_cnt);
    end
    step(0, 0, '0, 0, '0);
    n_checks++;
    if (ir_e !== 32'hac86_0004 || ir_d !== im(32'h0000_3010) || pc_f !== 32'h0000_3014 || ir_w !== 32'h0) begin
      n_fail++; $display("FAIL stall_release: got e=%h d=%h pc_f=%h w=%h", ir_e, ir_d, pc_f, ir_w);
    end
  endtask

  task automatic test_taken_branch();
    do_reset();
    for (int i = 0; i < 3; i++) step(0, 0, '0, 0, '0);
    step(0, 1, 32'h0000_3020, 0, '0);
    n_checks++;
    if (ir_d !== 32'hac86_0004 || pc_f !== 32'h0000_3020) begin
      n_fail++; $display("FAIL branch_slot: got ir_d=%h pc_f=%h expected ac860004 00003020", ir_d, pc_f);
    end
    step(0, 0, '0, 0, '0);
    n_checks++;
    if (ir_d !== im(32'h0000_3020) || pc_d !== 32'h0000_3020 || pc_f !== 32'h0000_3024) begin
      n_fail++; $display("FAIL branch_target: got ir_d=%h pc_d=%h pc_f=%h expected %h 00003020 00003024", ir_d, pc_d, pc_f, im(32'h0000_3020));
    end
  endtask

  task automatic test_branch_under_stall();
    do_reset();
    for (int i = 0; i < 3; i++) step(0, 0, '0, 0, '0);
    step(1, 1, 32'h0000_3020, 0, '0);
    n_checks++;
    if (pc_f !== 32'h0000_300C) begin
      n_fail++; $display("FAIL branch_stalled: got pc_f=%h expected 0000300c", pc_f);
    end
    step(0, 1, 32'h0000_3020, 0, '0);
    n_checks++;
    if (pc_f !== 32'h0000_3020) begin
      n_fail++; $display("FAIL branch_after_stall: got pc_f=%h expected 00003020", pc_f);
    end
    step(0, 1, 32'h0000_3020, 1, 32'h0000_3040);
    n_checks++;
    if (pc_f !== 32'h0000_3040) begin
      n_fail++; $display("FAIL jump_priority: got pc_f=%h expected 00003040", pc_f);
    end
  endtask

  task automatic test_wrap();
    step(0, 0, '0, 1, 32'hFFFF_FFFC);
    n_checks++;
    if (pc_f !== 32'hFFFF_FFFC) begin
      n_fail++; $display("FAIL wrap_jump: got pc_f=%h expected fffffffc", pc_f);
    end
    step(1, 0, '0, 0, '0);
    step(0, 0, '0, 0, '0);
    n_checks++;
    if (pc_f !== 32'h0 || pc_d !== 32'hFFFF_FFFC) begin
      n_fail++; $display("FAIL wrap_increment: got pc_f=%h pc_d=%h expected 00000000 fffffffc", pc_f, pc_d);
    end
  endtask

  task automatic test_reset_mid_run();
    int guard = 0;
    while (ir_e == 32'h0 && guard < 20) begin
      step(0, 0, '0, 0, '0);
      guard++;
    end
    n_checks++;
    if (ir_e == 32'h0) begin
      n_fail++; $display("FAIL midreset_setup: got ir_e=%h expected nonzero", ir_e);
    end
    reset = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (pc_f !== 32'h0000_3000 || {ir_d, ir_e, ir_m, ir_w, pc_w, stall_cnt, retired_cnt} !== 224'h0) begin
      n_fail++; $display("FAIL midreset_async: got pc_f=%h e=%h m=%h w=%h sc=%0d rc=%0d", pc_f, ir_e, ir_m, ir_w, stall_cnt, retired_cnt);
    end
    stall = 1'b1; jump = 1'b1; jump_target = 32'h0000_7000;
    @(posedge clk);
    #1;
    n_checks++;
    if (pc_f !== 32'h0000_3000 || ir_d !== 32'h0 || stall_cnt !== 32'h0) begin
      n_fail++; $display("FAIL midreset_hold: got pc_f=%h ir_d=%h sc=%0d expected 00003000 0 0", pc_f, ir_d, stall_cnt);
    end
    @(negedge clk);
    reset = 1'b1;
    step(0, 0, '0, 0, '0);
    n_checks++;
    if (pc_d !== 32'h0000_3000 || ir_d !== 32'h0085_1021 || pc_f !== 32'h0000_3004) begin
      n_fail++; $display("FAIL midreset_release: got pc_d=%h ir_d=%h pc_f=%h expected 00003000 00851021 00003004", pc_d, ir_d, pc_f);
    end
  endtask

  task automatic test_random();
    logic s, b, j;
    logic [31:0] bt, jt;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      s  = ($urandom_range(0, 9) < 3);
      b  = ($urandom_range(0, 9) < 2);
      j  = ($urandom_range(0, 9) < 1);
      bt = $urandom & 32'h0000_FFFC;
      jt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : $urandom;
      step(s, b, bt, j, jt);
      n_checks++;
      if ({pc_f, ir_d, pc_d, ir_e, pc_e, ir_m, pc_m, ir_w, pc_w, stall_cnt, retired_cnt} !==
          {m_pc, m_ir[0], m_pcs[0], m_ir[1], m_pcs[1], m_ir[2], m_pcs[2], m_ir[3], m_pcs[3], m_sc, m_rc}) begin
        n_fail++;
        $display("FAIL random_cycle%0d: got pc_f=%h d=%h/%h e=%h/%h m=%h/%h w=%h/%h sc=%0d rc=%0d expected pc_f=%h d=%h/%h e=%h/%h m=%h/%h w=%h/%h sc=%0d rc=%0d",
                 n, pc_f, ir_d, pc_d, ir_e, pc_e, ir_m, pc_m, ir_w, pc_w, stall_cnt, retired_cnt,
                 m_pc, m_ir[0], m_pcs[0], m_ir[1], m_pcs[1], m_ir[2], m_pcs[2], m_ir[3], m_pcs[3], m_sc, m_rc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_straight_line();
    test_load_use_stall();
    test_taken_branch();
    test_branch_under_stall();
    test_wrap();
    test_reset_mid_run();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
